// File: rtl/rr_arb_nmux.sv
// rtl/rr_arb_nmux.sv - M-channel round-robin arbitrating mux with a registered output stage
// Optional burst locking is enabled by defining RR_ARB_NMUX_LOCK_EN (adds the in_last port).
module rr_arb_nmux #(
  parameter int N = 32,
  parameter int M = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [M*N-1:0] in_data,
  input  logic [M-1:0]   in_valid,
  output logic [M-1:0]   in_ready,
`ifdef RR_ARB_NMUX_LOCK_EN
  input  logic [M-1:0]   in_last,
`endif
  output logic [N-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [$clog2(M)-1:0] out_sel
);

  localparam int SW = $clog2(M);

  logic [N-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] out_sel_q, out_sel_d;
  logic [SW-1:0] last_q, last_d;
  logic          lock_q, lock_d;

  logic [N-1:0]  ch_data [M];
  logic          can_load;
  logic          win_found;
  logic [SW-1:0] win_idx;
  logic          load;

  for (genvar i = 0; i < M; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*N +: N];
  end

  assign can_load = !out_valid_q || out_ready;

  // Search starts one past the last granted channel; a held lock pins the search to last_q.
  always_comb begin
    int            c;
    logic [SW-1:0] idx;
    win_found = 1'b0;
    win_idx   = '0;
    c         = 0;
    idx       = '0;
    if (lock_q) begin
      if (in_valid[last_q]) begin
        win_found = 1'b1;
        win_idx   = last_q;
      end
    end else begin
      for (int k = 1; k <= M; k++) begin
        c   = (int'(last_q) + k) % M;
        idx = SW'(c);
        if (!win_found && in_valid[idx]) begin
          win_found = 1'b1;
          win_idx   = idx;
        end
      end
    end
  end

  assign load = can_load && win_found && rst_n;

  always_comb begin
    in_ready = '0;
    if (load) begin
      in_ready[win_idx] = 1'b1;
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sel_d   = out_sel_q;
    last_d      = last_q;
    lock_d      = lock_q;
    if (load) begin
      out_data_d  = ch_data[win_idx];
      out_valid_d = 1'b1;
      out_sel_d   = win_idx;
      last_d      = win_idx;
`ifdef RR_ARB_NMUX_LOCK_EN
      lock_d      = !in_last[win_idx];
`else
      lock_d      = 1'b0;
`endif
    end else if (can_load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      last_q      <= SW'(M - 1);
      lock_q      <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      last_q      <= last_d;
      lock_q      <= lock_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;

endmodule
